// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter: serialises master 0/1 onto one slave port,
// routes ack/read data back to the owner, and forces an ack on slave timeout.
module dbus_arbiter #(
  parameter bit          p_rr      = 1'b1,
  parameter int unsigned p_timeout = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_be,
  input  logic        m0_wr_en,
  input  logic [31:0] m0_wr_data,
  input  logic        m0_rd_en,
  output logic [31:0] m0_rd_data,
  output logic        m0_busy,
  output logic        m0_ack,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_be,
  input  logic        m1_wr_en,
  input  logic [31:0] m1_wr_data,
  input  logic        m1_rd_en,
  output logic [31:0] m1_rd_data,
  output logic        m1_busy,
  output logic        m1_ack,
  output logic [31:0] s_addr,
  output logic [3:0]  s_be,
  output logic        s_wr_en,
  output logic [31:0] s_wr_data,
  output logic        s_rd_en,
  input  logic [31:0] s_rd_data,
  input  logic        s_busy,
  input  logic        s_ack,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  localparam int unsigned CNT_W = 8;
  // p_timeout == 0 wraps to all-ones here, but TO_EN masks it off
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(p_timeout - 1);
  localparam bit               TO_EN   = (p_timeout != 0);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic        req0, req1;
  logic        force_ack;
  logic        ack;
  logic [31:0] rd_mux;

  assign req0 = m0_rd_en | m0_wr_en;
  assign req1 = m1_rd_en | m1_wr_en;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Arbitration, owner routing and timeout; outputs follow the owner combinationally
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    s_addr     = '0;
    s_be       = '0;
    s_wr_en    = 1'b0;
    s_wr_data  = '0;
    s_rd_en    = 1'b0;
    o_grant    = 2'b00;
    o_timeout  = 1'b0;
    m0_busy    = req0;
    m1_busy    = req1;
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    m0_rd_data = '0;
    m1_rd_data = '0;
    force_ack  = TO_EN && (cnt_q == TO_LAST) && !s_ack;
    ack        = s_ack || force_ack;
    rd_mux     = force_ack ? 32'h0 : s_rd_data;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Tie goes to master 0 under fixed priority or when master 1 was served last
        if (req0 && (!req1 || !p_rr || last_q)) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        s_addr     = m0_addr;
        s_be       = m0_be;
        s_wr_en    = m0_wr_en;
        s_wr_data  = m0_wr_data;
        s_rd_en    = m0_rd_en;
        o_grant    = 2'b01;
        o_timeout  = force_ack;
        m0_busy    = s_busy;
        m0_ack     = ack;
        m0_rd_data = rd_mux;
        if (ack) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      OWN1: begin
        s_addr     = m1_addr;
        s_be       = m1_be;
        s_wr_en    = m1_wr_en;
        s_wr_data  = m1_wr_data;
        s_rd_en    = m1_rd_en;
        o_grant    = 2'b10;
        o_timeout  = force_ack;
        m1_busy    = s_busy;
        m1_ack     = ack;
        m1_rd_data = rd_mux;
        if (ack) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench for dbus_arbiter: round-robin/timeout instance (a) and
// fixed-priority/no-timeout instance (b) sharing address/data/slave inputs.
module tb_dbus_arbiter;

  typedef struct packed {
    logic [1:0]  grant;
    logic [31:0] rd;
    logic        to;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] m0_addr, m0_wr_data, m1_addr, m1_wr_data, s_rd_data;
  logic [3:0]  m0_be, m1_be;
  logic        s_busy, auto_ack, man_ack, b_auto;

  logic        a_m0_rd_en, a_m0_wr_en, a_m1_rd_en, a_m1_wr_en;
  logic [31:0] a_m0_rd_data, a_m1_rd_data, a_s_addr, a_s_wr_data;
  logic        a_m0_busy, a_m1_busy, a_m0_ack, a_m1_ack;
  logic [3:0]  a_s_be;
  logic        a_s_wr_en, a_s_rd_en, a_s_ack, a_o_timeout;
  logic [1:0]  a_o_grant;

  logic        b_m0_rd_en, b_m0_wr_en, b_m1_rd_en, b_m1_wr_en;
  logic [31:0] b_m0_rd_data, b_m1_rd_data, b_s_addr, b_s_wr_data;
  logic        b_m0_busy, b_m1_busy, b_m0_ack, b_m1_ack;
  logic [3:0]  b_s_be;
  logic        b_s_wr_en, b_s_rd_en, b_s_ack, b_o_timeout;
  logic [1:0]  b_o_grant;

  assign a_s_ack = (auto_ack & (a_s_rd_en | a_s_wr_en)) | man_ack;
  assign b_s_ack = b_auto & (b_s_rd_en | b_s_wr_en);

  dbus_arbiter #(.p_rr(1'b1), .p_timeout(4)) u_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .m0_addr(m0_addr), .m0_be(m0_be), .m0_wr_en(a_m0_wr_en), .m0_wr_data(m0_wr_data),
    .m0_rd_en(a_m0_rd_en), .m0_rd_data(a_m0_rd_data), .m0_busy(a_m0_busy), .m0_ack(a_m0_ack),
    .m1_addr(m1_addr), .m1_be(m1_be), .m1_wr_en(a_m1_wr_en), .m1_wr_data(m1_wr_data),
    .m1_rd_en(a_m1_rd_en), .m1_rd_data(a_m1_rd_data), .m1_busy(a_m1_busy), .m1_ack(a_m1_ack),
    .s_addr(a_s_addr), .s_be(a_s_be), .s_wr_en(a_s_wr_en), .s_wr_data(a_s_wr_data),
    .s_rd_en(a_s_rd_en), .s_rd_data(s_rd_data), .s_busy(s_busy), .s_ack(a_s_ack),
    .o_grant(a_o_grant), .o_timeout(a_o_timeout)
  );

  dbus_arbiter #(.p_rr(1'b0), .p_timeout(0)) u_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .m0_addr(m0_addr), .m0_be(m0_be), .m0_wr_en(b_m0_wr_en), .m0_wr_data(m0_wr_data),
    .m0_rd_en(b_m0_rd_en), .m0_rd_data(b_m0_rd_data), .m0_busy(b_m0_busy), .m0_ack(b_m0_ack),
    .m1_addr(m1_addr), .m1_be(m1_be), .m1_wr_en(b_m1_wr_en), .m1_wr_data(m1_wr_data),
    .m1_rd_en(b_m1_rd_en), .m1_rd_data(b_m1_rd_data), .m1_busy(b_m1_busy), .m1_ack(b_m1_ack),
    .s_addr(b_s_addr), .s_be(b_s_be), .s_wr_en(b_s_wr_en), .s_wr_data(b_s_wr_data),
    .s_rd_en(b_s_rd_en), .s_rd_data(s_rd_data), .s_busy(s_busy), .s_ack(b_s_ack),
    .o_grant(b_o_grant), .o_timeout(b_o_timeout)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic [1:0] gseq [0:6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int k, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if ((k == 0) ? a_m0_ack : a_m1_ack) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_ack m%0d: no ack within %0d cycles", k, budget);
    end
  endtask

  // Instance a monitor: every ack/timeout pops one expectation
  always @(negedge clk) begin
    if (a_m0_ack || a_m1_ack || a_o_timeout) begin
      if (qa.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL a_unexpected_ack: ack=%b%b timeout=%b, expected none",
                 a_m1_ack, a_m0_ack, a_o_timeout);
      end else begin
        ea = qa.pop_front();
        chk("a_ack_who", 32'({a_m1_ack, a_m0_ack}), 32'(ea.grant));
        chk("a_grant", 32'(a_o_grant), 32'(ea.grant));
        chk("a_rd_data", ea.grant[1] ? a_m1_rd_data : a_m0_rd_data, ea.rd);
        chk("a_other_rd", ea.grant[1] ? a_m0_rd_data : a_m1_rd_data, 32'h0);
        chk("a_timeout", 32'(a_o_timeout), 32'(ea.to));
      end
    end
  end

  // Instance b monitor
  always @(negedge clk) begin
    if (b_m0_ack || b_m1_ack || b_o_timeout) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL b_unexpected_ack: ack=%b%b timeout=%b, expected none",
                 b_m1_ack, b_m0_ack, b_o_timeout);
      end else begin
        eb = qb.pop_front();
        chk("b_ack_who", 32'({b_m1_ack, b_m0_ack}), 32'(eb.grant));
        chk("b_grant", 32'(b_o_grant), 32'(eb.grant));
        chk("b_rd_data", eb.grant[1] ? b_m1_rd_data : b_m0_rd_data, eb.rd);
        chk("b_timeout", 32'(b_o_timeout), 32'(eb.to));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    gseq[0] = 2'b01; gseq[1] = 2'b00; gseq[2] = 2'b10; gseq[3] = 2'b00;
    gseq[4] = 2'b01; gseq[5] = 2'b00; gseq[6] = 2'b10;
    rst_n = 1'b0;
    m0_addr = '0; m0_wr_data = '0; m0_be = 4'hF;
    m1_addr = '0; m1_wr_data = '0; m1_be = 4'hF;
    s_rd_data = '0; s_busy = 1'b0; auto_ack = 1'b0; man_ack = 1'b0; b_auto = 1'b0;
    a_m0_rd_en = 1'b1; a_m0_wr_en = 1'b0; a_m1_rd_en = 1'b0; a_m1_wr_en = 1'b0;
    b_m0_rd_en = 1'b0; b_m0_wr_en = 1'b0; b_m1_rd_en = 1'b0; b_m1_wr_en = 1'b0;

    // Reset state with a pending request
    repeat (2) @(negedge clk);
    chk("rst_s_rd_en", 32'(a_s_rd_en), 32'h0);
    chk("rst_s_addr", a_s_addr, 32'h0);
    chk("rst_grant", 32'(a_o_grant), 32'h0);
    chk("rst_m0_busy", 32'(a_m0_busy), 32'h1);
    chk("rst_m0_ack", 32'(a_m0_ack), 32'h0);
    chk("rst_m0_rd", a_m0_rd_data, 32'h0);
    a_m0_rd_en = 1'b0;
    rst_n = 1'b1;

    // Single read by m0 with immediate ack
    cyc();
    m0_addr = 32'h100; s_rd_data = 32'hA5A5_0001; auto_ack = 1'b1; a_m0_rd_en = 1'b1;
    qa.push_back({2'b01, 32'hA5A5_0001, 1'b0});
    @(negedge clk); chk("rd_t_grant", 32'(a_o_grant), 32'h0);
    cyc();
    @(negedge clk);
    chk("rd_s_rd_en", 32'(a_s_rd_en), 32'h1);
    chk("rd_s_addr", a_s_addr, 32'h100);
    cyc();
    a_m0_rd_en = 1'b0;
    @(negedge clk); chk("rd_idle_grant", 32'(a_o_grant), 32'h0);

    // Round-robin order out of reset: m0, m1, m0, m1
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    cyc();
    s_rd_data = 32'h1111_2222; a_m0_rd_en = 1'b1; a_m1_rd_en = 1'b1;
    for (int i = 0; i < 4; i++) qa.push_back({(i % 2 == 0) ? 2'b01 : 2'b10, 32'h1111_2222, 1'b0});
    for (int i = 0; i < 7; i++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("rr_grant%0d", i), 32'(a_o_grant), 32'(gseq[i]));
      if (i == 0) chk("rr_m1_busy", 32'(a_m1_busy), 32'h1);
    end
    cyc();
    a_m0_rd_en = 1'b0; a_m1_rd_en = 1'b0; auto_ack = 1'b0;

    // Fixed priority: m0 wins every arbitration while both are held
    b_m0_rd_en = 1'b1; b_m1_rd_en = 1'b1; b_auto = 1'b1;
    for (int i = 0; i < 3; i++) qb.push_back({2'b01, 32'h1111_2222, 1'b0});
    for (int i = 0; i < 5; i++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("fp_grant%0d", i), 32'(b_o_grant), (i % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("fp_m1_busy%0d", i), 32'(b_m1_busy), 32'h1);
    end
    cyc();
    b_m0_rd_en = 1'b0; b_m1_rd_en = 1'b0; b_auto = 1'b0;

    // m1 write passthrough with s_busy for 3 cycles, ack in the 4th OWN cycle
    cyc();
    m1_addr = 32'h2000_0004; m1_be = 4'hC; m1_wr_data = 32'h1234_5678;
    a_m1_wr_en = 1'b1; s_busy = 1'b1; s_rd_data = 32'h5555_AAAA;
    qa.push_back({2'b10, 32'h5555_AAAA, 1'b0});
    qa.push_back({2'b01, 32'h5555_AAAA, 1'b0});
    cyc();
    @(negedge clk);
    chk("wr_s_addr", a_s_addr, 32'h2000_0004);
    chk("wr_s_be", 32'(a_s_be), 32'hC);
    chk("wr_s_data", a_s_wr_data, 32'h1234_5678);
    chk("wr_s_wr_en", 32'(a_s_wr_en), 32'h1);
    chk("wr_s_rd_en", 32'(a_s_rd_en), 32'h0);
    chk("wr_grant", 32'(a_o_grant), 32'h2);
    chk("wr_m1_busy1", 32'(a_m1_busy), 32'h1);
    chk("wr_m0_busy_idle", 32'(a_m0_busy), 32'h0);
    cyc();
    a_m0_rd_en = 1'b1; m0_addr = 32'h40;
    @(negedge clk);
    chk("wr_m1_busy2", 32'(a_m1_busy), 32'h1);
    chk("wr_m0_busy_req", 32'(a_m0_busy), 32'h1);
    chk("wr_m0_rd", a_m0_rd_data, 32'h0);
    cyc();
    @(negedge clk);
    chk("wr_m1_busy3", 32'(a_m1_busy), 32'h1);
    chk("wr_m1_ack3", 32'(a_m1_ack), 32'h0);
    cyc();
    s_busy = 1'b0; man_ack = 1'b1;
    @(negedge clk); chk("wr_m1_busy4", 32'(a_m1_busy), 32'h0);
    cyc();
    man_ack = 1'b0; a_m1_wr_en = 1'b0; auto_ack = 1'b1;
    @(negedge clk);
    chk("wr_bubble_grant", 32'(a_o_grant), 32'h0);
    chk("wr_bubble_m0_busy", 32'(a_m0_busy), 32'h1);
    wait_ack(0, 4);
    cyc();
    a_m0_rd_en = 1'b0; auto_ack = 1'b0;

    // Timeout: s_ack never arrives, forced ack in the 4th OWN cycle
    cyc();
    m0_addr = 32'h80; s_rd_data = 32'hFFFF_FFFF; a_m0_rd_en = 1'b1;
    qa.push_back({2'b01, 32'h0, 1'b1});
    for (int i = 1; i <= 3; i++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("to_ack_c%0d", i), 32'(a_m0_ack), 32'h0);
      chk($sformatf("to_flag_c%0d", i), 32'(a_o_timeout), 32'h0);
    end
    cyc();
    @(negedge clk);
    cyc();
    a_m0_rd_en = 1'b0;
    @(negedge clk); chk("to_idle_grant", 32'(a_o_grant), 32'h0);

    // Spurious s_ack in IDLE
    cyc();
    man_ack = 1'b1;
    @(negedge clk);
    chk("sp_grant", 32'(a_o_grant), 32'h0);
    chk("sp_m0_ack", 32'(a_m0_ack), 32'h0);
    chk("sp_m1_ack", 32'(a_m1_ack), 32'h0);
    cyc();
    @(negedge clk); chk("sp_grant2", 32'(a_o_grant), 32'h0);
    cyc();
    man_ack = 1'b0;

    // Reset mid-OWN1 with s_busy, then tie goes to m0
    m1_addr = 32'h300; a_m1_rd_en = 1'b1; a_m1_wr_en = 1'b0; s_busy = 1'b1;
    cyc();
    a_m0_rd_en = 1'b1;
    cyc();
    @(negedge clk); chk("mr_grant", 32'(a_o_grant), 32'h2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mr_s_rd_en", 32'(a_s_rd_en), 32'h0);
    chk("mr_s_addr", a_s_addr, 32'h0);
    chk("mr_grant_rst", 32'(a_o_grant), 32'h0);
    chk("mr_m1_ack", 32'(a_m1_ack), 32'h0);
    chk("mr_m1_busy", 32'(a_m1_busy), 32'h1);
    @(negedge clk);
    rst_n = 1'b1; s_busy = 1'b0; auto_ack = 1'b1; s_rd_data = 32'h7777_0000;
    qa.push_back({2'b01, 32'h7777_0000, 1'b0});
    qa.push_back({2'b10, 32'h7777_0000, 1'b0});
    wait_ack(1, 8);
    cyc();
    a_m0_rd_en = 1'b0; a_m1_rd_en = 1'b0; auto_ack = 1'b0;

    repeat (3) @(negedge clk);
    chk("qa_drained", 32'(qa.size()), 32'h0);
    chk("qb_drained", 32'(qb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Two-master arbiter that shares the single data-memory bus between the core's memory stage (master 0) and a secondary master such as a debug or DMA port (master 1). It sits between the memory stage's dbus outputs and the data memory or peripheral interconnect. It serialises transactions and routes ack and read data back to the owner. A per-transaction timeout turns a hung slave into a forced acknowledge.

## Interface
- p_rr, default 1: 1 = round-robin, 0 = fixed priority (master 0 wins).
- p_timeout, default 0: cycles an owner may wait for s_ack before a forced ack; 0 disables; legal 0..255.
- i_clk  in  1  global clock, rising edge.
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- m0_addr / m1_addr  in  32  word address (bits [1:0] = 0).
- m0_be / m1_be  in  4  write byte enable.
- m0_wr_en / m1_wr_en  in  1  write request.
- m0_wr_data / m1_wr_data  in  32  write data.
- m0_rd_en / m1_rd_en  in  1  read request.
- m0_rd_data / m1_rd_data  out  32  read data.
- m0_busy / m1_busy  out  1  master must hold its request.
- m0_ack / m1_ack  out  1  transfer complete.
- s_addr, s_be, s_wr_en, s_wr_data, s_rd_en  out  32/4/1/32/1  slave-side request.
- s_rd_data  in  32  slave read data.
- s_busy  in  1  slave busy.
- s_ack  in  1  slave acknowledge.
- o_grant  out  2  one-hot current owner (bit k = master k).
- o_timeout  out  1  one-cycle pulse on a forced ack.

## Operation
- A master requests when rd_en|wr_en = 1. It holds all request fields stable until the cycle its ack = 1, and may drop the request the following cycle.
- FSM states are IDLE, OWN0 and OWN1. Arbitration state is registered: last-served pointer `last` and timeout counter `cnt`, 8 bits.
- IDLE:
  - Slave outputs are all 0.
  - If no request, stay in IDLE.
  - If only master k requests, go to OWNk.
  - If both request and p_rr=1, go to OWN(1-last). If p_rr=0, go to OWN0.
- OWNk:
  - s_* outputs = master k's fields, unmodified.
  - m_k_busy = s_busy. m_k_ack = s_ack or forced ack. m_k_rd_data = s_rd_data.
  - Non-owner: busy = its request, ack = 0, rd_data = 0.
- Completion: when m_k_ack = 1, next state is IDLE and last <= k. There is always one IDLE bubble between transactions.
- Idle-state master outputs: busy = own request, ack = 0, rd_data = 0.
- Timeout (p_timeout > 0):
  - cnt <= 0 on entering OWNk, and increments each OWN cycle without ack.
  - When cnt == p_timeout-1 and s_ack = 0, assert forced ack and o_timeout = 1 in that cycle. m_k_rd_data is 32'h0 in that cycle.
  - If s_ack = 1 in the same cycle, it is a normal ack and o_timeout = 0.
- Late or spurious s_ack:
  - A late s_ack arriving in IDLE is ignored.
  - s_ack while OWNk and the owner's request is low cannot occur under protocol. It completes the transfer anyway.
- o_grant = 2'b01 in OWN0, 2'b10 in OWN1, 2'b00 in IDLE.

## Timing
- Reset (asynchronous):
  - State goes to IDLE, last = 1 (first round-robin tie goes to master 0), cnt = 0.
  - s_* = 0, o_grant = 0, o_timeout = 0, m_ack = 0, m_rd_data = 0.
  - m_busy follows request.
- Reset mid-transaction abandons it: no ack is delivered and slave outputs drop immediately.
- Grant latency: a request in IDLE at cycle t is on s_* at cycle t+1.
- Minimum transaction is 2 cycles (IDLE + OWN with immediate s_ack). Back-to-back throughput is one transfer per 2 cycles.
- Ack and read data are combinational from s_ack/s_rd_data in the owning cycle, which matches the memory stage's registered capture.
- Request arriving in the same cycle as another master's ack: it wins the next arbitration in IDLE. Under round-robin a sole waiting master never starves.
- Forced ack occurs in the p_timeout-th cycle of ownership.

## Test plan
- Single read by m0: m0_rd_en=1, addr=0x100, s_ack=1 in the first OWN cycle with s_rd_data=0xA5A5_0001 -> s_rd_en at t+1, m0_ack=1 and m0_rd_data=0xA5A5_0001 at t+1, o_grant=01, IDLE at t+2.
- Simultaneous requests with p_rr=1, out of reset, immediate acks -> order is m0, m1, m0, m1. m1_busy=1 while m0 owns. p_rr=0 with both held -> m0 served every transaction.
- Write passthrough: m1 write addr=0x2000_0004, be=0xC, data=0x1234_5678 -> identical values on s_*. s_busy=1 for 3 cycles reflects on m1_busy. m0 is unaffected.
- Timeout with p_timeout=4 and s_ack never asserted -> m0_ack=1, o_timeout=1, rd_data=0 in the 4th OWN cycle, then IDLE. With s_ack=1 exactly in the 4th cycle -> normal ack, o_timeout=0.
- Reset asserted mid-OWN1 with s_busy=1 -> s_* and o_grant=0 asynchronously, no ack. After release, a pending m0/m1 tie grants m0.
- Spurious s_ack in IDLE -> no m_ack, state unchanged.
